// File: rtl/offset_unbias_serializer.sv
// offset_unbias_serializer
//
// Purpose:
//   This block is the inverse of the shared-offset biasing stage. It accepts one
//   bundle per transfer. A bundle holds three biased sums and the common signed
//   offset. The block removes the offset from each sum, range-checks the result,
//   and emits channels 0, 1 and 2 serially over a valid/ready interface.
//
//   For each channel:
//     diff    = {0,sum[ch]} - sext(ofs)        (SUM_W+1 bits, signed)
//     out_val = diff[VAL_W-1:0]                (the wrap is intentional)
//     out_err = diff < 0 || diff > 2^VAL_W-1
//
// Ports:
//   clk        in   1      clock; all state changes on the rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      bundle present on in_* this cycle
//   in_ready   out  1      block can accept a bundle (high in IDLE)
//   in_ofs     in   OFS_W  signed offset applied by the upstream biasing
//   in_sum_a   in   SUM_W  biased sum, channel 0
//   in_sum_b   in   SUM_W  biased sum, channel 1
//   in_sum_c   in   SUM_W  biased sum, channel 2
//   out_valid  out  1      out_ch/out_val/out_err/out_last are valid
//   out_ready  in   1      consumer takes the current channel
//   out_ch     out  2      channel index 0..2
//   out_val    out  VAL_W  recovered value (low VAL_W bits of diff)
//   out_err    out  1      recovered value is out of range
//   out_last   out  1      high with out_valid on channel 2
//   err_cnt    out  8      saturating count of accepted error beats
//                          (present only when OFFSET_UNBIAS_ERRCNT_EN is defined)
//
// Configuration macro:
//   OFFSET_UNBIAS_ERRCNT_EN  adds the err_cnt port and its counter.

module offset_unbias_serializer #(
  parameter int VAL_W = 3,
  parameter int OFS_W = 2,
  parameter int SUM_W = VAL_W + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OFS_W-1:0] in_ofs,
  input  logic [SUM_W-1:0] in_sum_a,
  input  logic [SUM_W-1:0] in_sum_b,
  input  logic [SUM_W-1:0] in_sum_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_ch,
  output logic [VAL_W-1:0] out_val,
  output logic             out_err,
  output logic             out_last
`ifdef OFFSET_UNBIAS_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam int DIFF_W = SUM_W + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  // Subtracts the sign-extended offset from the zero-extended sum.
  function automatic logic signed [DIFF_W-1:0] unbias(
    input logic        [SUM_W-1:0] sum,
    input logic signed [OFS_W-1:0] ofs
  );
    logic signed [DIFF_W-1:0] sum_ext;
    logic signed [DIFF_W-1:0] ofs_ext;
    sum_ext = $signed({1'b0, sum});
    ofs_ext = {{(DIFF_W-OFS_W){ofs[OFS_W-1]}}, ofs};
    return sum_ext - ofs_ext;
  endfunction

  // A value is out of range when it is negative, or when any bit above the
  // low VAL_W bits is set (which means it exceeds 2^VAL_W-1).
  function automatic logic out_of_range(input logic signed [DIFF_W-1:0] d);
    return d[DIFF_W-1] || (d[DIFF_W-2:VAL_W] != '0);
  endfunction

  state_t                   state_q;
  state_t                   state_d;
  logic [1:0]               ch_q;
  logic [1:0]               ch_d;

  logic signed [OFS_W-1:0]  ofs_p0;
  logic        [SUM_W-1:0]  sum_a_p0;
  logic        [SUM_W-1:0]  sum_b_p0;
  logic        [SUM_W-1:0]  sum_c_p0;

  logic                     in_accept;
  logic                     out_accept;
  logic        [SUM_W-1:0]  sum_sel;
  logic signed [DIFF_W-1:0] diff;
  logic                     emit;

  assign emit       = (state_q == S_EMIT);
  assign in_ready   = (state_q == S_IDLE);
  assign in_accept  = in_valid && in_ready;
  assign out_accept = out_valid && out_ready;

  // ---- Stage p0: bundle capture on input accept ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ofs_p0   <= '0;
      sum_a_p0 <= '0;
      sum_b_p0 <= '0;
      sum_c_p0 <= '0;
    end else if (in_accept) begin
      ofs_p0   <= $signed(in_ofs);
      sum_a_p0 <= in_sum_a;
      sum_b_p0 <= in_sum_b;
      sum_c_p0 <= in_sum_c;
    end
  end

  // Serializer control: state and channel index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      S_IDLE: begin
        ch_d = 2'd0;
        if (in_valid) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (ch_q == 2'd2) begin
            state_d = S_IDLE;
            ch_d    = 2'd0;
          end else begin
            ch_d = ch_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ch_d    = 2'd0;
      end
    endcase
  end

  // ---- Stage p0 -> output: combinational unbias of the selected channel ----
  always_comb begin
    sum_sel = sum_a_p0;
    case (ch_q)
      2'd0:    sum_sel = sum_a_p0;
      2'd1:    sum_sel = sum_b_p0;
      2'd2:    sum_sel = sum_c_p0;
      default: sum_sel = sum_a_p0;
    endcase
  end

  assign diff = unbias(sum_sel, ofs_p0);

  // Outputs are forced to zero outside EMIT, so stale capture data never
  // shows while idle. During backpressure nothing they depend on can change.
  assign out_valid = emit;
  assign out_ch    = ch_q;
  assign out_val   = emit ? diff[VAL_W-1:0] : '0;
  assign out_err   = emit && out_of_range(diff);
  assign out_last  = emit && (ch_q == 2'd2);

`ifdef OFFSET_UNBIAS_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (out_accept && out_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  // Kept so the accept term has a consumer when the counter is built out.
  logic unused_out_accept;
  assign unused_out_accept = out_accept;
`endif

endmodule
